// File: rtl/cvxif_result_buffer_pkg.sv
// Shared constants for the CV-X-IF coprocessor result path.
// The coprocessor top passes ResultBufDepth as the result buffer depth.
package cvxif_result_buffer_pkg;

    localparam int unsigned ResultBufDepth   = 4;
    localparam int unsigned ResultBufReserve = 1;
    localparam int unsigned ResultDataWidth  = 64;
    localparam int unsigned ResultRegWidth   = 5;

endpackage

// File: rtl/cvxif_result_buffer.sv
// In-order result FIFO between the coprocessor ALU and the CV-X-IF result channel.
// Captures one-cycle ALU result pulses and holds the head entry stable until the CPU accepts it.
module cvxif_result_buffer
    import cvxif_result_buffer_pkg::*;
#(
    parameter int unsigned Depth    = ResultBufDepth,
    parameter int unsigned Reserve  = ResultBufReserve,
    parameter type         hartid_t = logic,
    parameter type         id_t     = logic
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       alu_valid_i,
    input  hartid_t                    hartid_i,
    input  id_t                        id_i,
    input  logic [ResultDataWidth-1:0] data_i,
    input  logic [ResultRegWidth-1:0]  rd_i,
    input  logic                       we_i,
    input  logic                       flush_i,
    output logic                       result_valid_o,
    input  logic                       result_ready_i,
    output hartid_t                    result_hartid_o,
    output id_t                        result_id_o,
    output logic [ResultDataWidth-1:0] result_data_o,
    output logic [ResultRegWidth-1:0]  result_rd_o,
    output logic                       result_we_o,
    output logic                       almost_full_o,
    output logic [$clog2(Depth):0]     count_o,
    output logic                       overflow_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    typedef struct packed {
        hartid_t                    hartid;
        id_t                        id;
        logic [ResultDataWidth-1:0] data;
        logic [ResultRegWidth-1:0]  rd;
        logic                       we;
    } entry_t;

    entry_t            r_mem [Depth];
    logic [PtrW-1:0]   r_wptr;
    logic [PtrW-1:0]   r_rptr;
    logic [CntW-1:0]   r_count;
    logic              r_valid;
    logic              r_almost_full;
    logic              r_overflow;

    entry_t            w_entry;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [PtrW-1:0]   w_wptr_nxt;
    logic [PtrW-1:0]   w_rptr_nxt;
    logic [CntW-1:0]   w_count_nxt;
    logic              w_valid_nxt;
    logic              w_almost_full_nxt;
    logic              w_overflow_nxt;

    assign w_entry = '{hartid: hartid_i, id: id_i, data: data_i, rd: rd_i, we: we_i};

    // Handshake decode and next-state for pointers, occupancy and flags.
    always_comb begin
        w_full            = (r_count == CntW'(Depth));
        w_pop             = r_valid && result_ready_i;
        // A full buffer still accepts a push when the head leaves in the same cycle.
        w_push            = alu_valid_i && (!w_full || w_pop);
        w_drop            = alu_valid_i && w_full && !w_pop;
        w_wptr_nxt        = r_wptr;
        w_rptr_nxt        = r_rptr;
        w_count_nxt       = r_count;
        w_overflow_nxt    = r_overflow;
        if (flush_i) begin
            w_wptr_nxt     = {PtrW{1'b0}};
            w_rptr_nxt     = {PtrW{1'b0}};
            w_count_nxt    = {CntW{1'b0}};
            w_overflow_nxt = 1'b0;
        end else begin
            if (w_push) begin
                w_wptr_nxt = r_wptr + PtrW'(1);
            end else begin
                w_wptr_nxt = r_wptr;
            end
            if (w_pop) begin
                w_rptr_nxt = r_rptr + PtrW'(1);
            end else begin
                w_rptr_nxt = r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   w_count_nxt = r_count + CntW'(1);
                2'b01:   w_count_nxt = r_count - CntW'(1);
                default: w_count_nxt = r_count;
            endcase
            if (w_drop) begin
                w_overflow_nxt = 1'b1;
            end else begin
                w_overflow_nxt = r_overflow;
            end
        end
        w_valid_nxt       = (w_count_nxt != {CntW{1'b0}});
        w_almost_full_nxt = ((CntW'(Depth) - w_count_nxt) <= CntW'(Reserve));
    end

    // Control state: pointers, occupancy and the registered status outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr        <= {PtrW{1'b0}};
            r_rptr        <= {PtrW{1'b0}};
            r_count       <= {CntW{1'b0}};
            r_valid       <= 1'b0;
            r_almost_full <= 1'b0;
            r_overflow    <= 1'b0;
        end else begin
            r_wptr        <= w_wptr_nxt;
            r_rptr        <= w_rptr_nxt;
            r_count       <= w_count_nxt;
            r_valid       <= w_valid_nxt;
            r_almost_full <= w_almost_full_nxt;
            r_overflow    <= w_overflow_nxt;
        end
    end

    // Entry storage is left unreset; entries are only read while counted as occupied.
    always_ff @(posedge clk_i) begin
        if (w_push && !flush_i) begin
            r_mem[r_wptr] <= w_entry;
        end
    end

    assign result_valid_o  = r_valid;
    assign result_hartid_o = r_mem[r_rptr].hartid;
    assign result_id_o     = r_mem[r_rptr].id;
    assign result_data_o   = r_mem[r_rptr].data;
    assign result_rd_o     = r_mem[r_rptr].rd;
    assign result_we_o     = r_mem[r_rptr].we;
    assign almost_full_o   = r_almost_full;
    assign count_o         = r_count;
    assign overflow_o      = r_overflow;

endmodule

// File: tb/tb_cvxif_result_buffer.sv
// Directed bench for cvxif_result_buffer: queue-based reference model checked every cycle,
// plus literal expectations on the scenarios of interest.
module tb_cvxif_result_buffer;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned RESERVE = 1;

    typedef struct packed {
        logic [1:0]  h;
        logic [7:0]  id;
        logic [63:0] d;
        logic [4:0]  rd;
        logic        we;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        alu_valid_i = 1'b0;
    logic [1:0]  hartid_i = 2'd0;
    logic [7:0]  id_i = 8'd0;
    logic [63:0] data_i = 64'd0;
    logic [4:0]  rd_i = 5'd0;
    logic        we_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        result_ready_i = 1'b0;
    logic        result_valid_o;
    logic [1:0]  result_hartid_o;
    logic [7:0]  result_id_o;
    logic [63:0] result_data_o;
    logic [4:0]  result_rd_o;
    logic        result_we_o;
    logic        almost_full_o;
    logic [2:0]  count_o;
    logic        overflow_o;

    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 1'b0;
    ent_t mq[$];
    bit   movf = 1'b0;

    cvxif_result_buffer #(
        .Depth   (DEPTH),
        .Reserve (RESERVE),
        .hartid_t(logic [1:0]),
        .id_t    (logic [7:0])
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .alu_valid_i    (alu_valid_i),
        .hartid_i       (hartid_i),
        .id_i           (id_i),
        .data_i         (data_i),
        .rd_i           (rd_i),
        .we_i           (we_i),
        .flush_i        (flush_i),
        .result_valid_o (result_valid_o),
        .result_ready_i (result_ready_i),
        .result_hartid_o(result_hartid_o),
        .result_id_o    (result_id_o),
        .result_data_o  (result_data_o),
        .result_rd_o    (result_rd_o),
        .result_we_o    (result_we_o),
        .almost_full_o  (almost_full_o),
        .count_o        (count_o),
        .overflow_o     (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-cycle comparison of the DUT against the reference queue.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_valid", 128'(result_valid_o), 128'(mq.size() != 0));
            chk("model_count", 128'(count_o), 128'(mq.size()));
            chk("model_afull", 128'(almost_full_o), 128'((DEPTH - mq.size()) <= RESERVE));
            chk("model_ovf", 128'(overflow_o), 128'(movf));
            if (mq.size() != 0 && result_valid_o) begin
                chk("model_head",
                    128'({result_hartid_o, result_id_o, result_data_o, result_rd_o, result_we_o}),
                    128'(mq[0]));
            end
        end
    end

    // Drive one cycle of inputs (called at a negedge), then advance the model at the edge.
    task automatic cyc(input logic v, input logic [7:0] id, input logic [63:0] d,
                       input logic [4:0] rd, input logic we, input logic rdy, input logic fl);
        bit   pop;
        ent_t e;
        alu_valid_i    = v;
        hartid_i       = id[1:0];
        id_i           = id;
        data_i         = d;
        rd_i           = rd;
        we_i           = we;
        result_ready_i = rdy;
        flush_i        = fl;
        @(posedge clk);
        if (fl) begin
            mq.delete();
            movf = 1'b0;
        end else begin
            pop = (mq.size() != 0) && rdy;
            if (pop) void'(mq.pop_front());
            if (v) begin
                if (mq.size() < DEPTH) begin
                    e = '{h: id[1:0], id: id, d: d, rd: rd, we: we};
                    mq.push_back(e);
                end else begin
                    movf = 1'b1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b0, 8'd0, 64'd0, 5'd0, 1'b0, rdy, 1'b0);
    endtask

    initial begin
        logic [7:0] ins[$];
        logic [7:0] outs[$];
        int         pushed;
        int         guard;
        logic       rdy;

        // Reset held
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 128'(result_valid_o), 128'd0);
        chk("rst_count", 128'(count_o), 128'd0);
        chk("rst_afull", 128'(almost_full_o), 128'd0);
        chk("rst_ovf", 128'(overflow_o), 128'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        chk_en = 1'b1;
        repeat (5) idle(1'b0);
        chk("idle_count", 128'(count_o), 128'd0);

        // Single pass
        cyc(1'b1, 8'd3, 64'hDEAD_BEEF, 5'd7, 1'b1, 1'b1, 1'b0);
        chk("single_valid", 128'(result_valid_o), 128'd1);
        chk("single_id", 128'(result_id_o), 128'd3);
        chk("single_data", 128'(result_data_o), 128'hDEAD_BEEF);
        chk("single_rd", 128'(result_rd_o), 128'd7);
        chk("single_we", 128'(result_we_o), 128'd1);
        idle(1'b1);
        chk("single_empty_valid", 128'(result_valid_o), 128'd0);
        chk("single_empty_count", 128'(count_o), 128'd0);

        // Backpressure fill
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 8'(i), 64'(i) * 64'h1111, 5'(i + 1), 1'b0, 1'b0, 1'b0);
            if (i == 1) chk("bp_afull_lo", 128'(almost_full_o), 128'd0);
            if (i == 2) chk("bp_afull_at3", 128'(almost_full_o), 128'd1);
        end
        chk("bp_count4", 128'(count_o), 128'd4);
        chk("bp_head0", 128'(result_id_o), 128'd0);

        // Full boundary: push with pop accepted, push without pop dropped
        cyc(1'b1, 8'd9, 64'h99, 5'd9, 1'b1, 1'b1, 1'b0);
        chk("full_pp_count", 128'(count_o), 128'd4);
        chk("full_pp_ovf", 128'(overflow_o), 128'd0);
        chk("full_pp_head", 128'(result_id_o), 128'd1);
        cyc(1'b1, 8'd10, 64'hAA, 5'd10, 1'b1, 1'b0, 1'b0);
        chk("full_drop_ovf", 128'(overflow_o), 128'd1);
        chk("full_drop_head", 128'(result_id_o), 128'd1);
        chk("full_drop_count", 128'(count_o), 128'd4);
        begin
            logic [7:0] exp_ids [4] = '{8'd1, 8'd2, 8'd3, 8'd9};
            for (int i = 0; i < 4; i++) begin
                chk("drain_order", 128'(result_id_o), 128'(exp_ids[i]));
                idle(1'b1);
            end
        end
        chk("drain_valid", 128'(result_valid_o), 128'd0);
        chk("drain_ovf_sticky", 128'(overflow_o), 128'd1);

        // Flush with a simultaneous push and ready
        for (int i = 0; i < 3; i++) cyc(1'b1, 8'(20 + i), 64'(i), 5'd1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 8'd30, 64'h30, 5'd3, 1'b1, 1'b1, 1'b1);
        chk("flush_count", 128'(count_o), 128'd0);
        chk("flush_valid", 128'(result_valid_o), 128'd0);
        chk("flush_ovf", 128'(overflow_o), 128'd0);
        idle(1'b1);
        chk("flush_absent", 128'(result_valid_o), 128'd0);

        // Reset mid-operation
        cyc(1'b1, 8'd50, 64'h50, 5'd5, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 8'd51, 64'h51, 5'd5, 1'b1, 1'b0, 1'b0);
        #2;
        chk_en = 1'b0;
        rst_ni = 1'b0;
        #1;
        chk("midrst_valid", 128'(result_valid_o), 128'd0);
        chk("midrst_count", 128'(count_o), 128'd0);
        mq.delete();
        movf = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        chk_en = 1'b1;
        idle(1'b0);

        // Wrap-around stream with random ready
        pushed = 0;
        guard  = 0;
        while ((pushed < 20 || mq.size() != 0) && guard < 200) begin
            rdy = (pushed < 20) ? 1'($urandom_range(0, 1)) : 1'b1;
            if (result_valid_o && rdy) outs.push_back(result_id_o);
            if (pushed < 20 && (mq.size() < DEPTH || rdy)) begin
                ins.push_back(8'(40 + pushed));
                cyc(1'b1, 8'(40 + pushed), 64'(pushed) << 8, 5'(pushed), pushed[0], rdy, 1'b0);
                pushed++;
            end else begin
                idle(rdy);
            end
            if (count_o > 3'd4) chk("wrap_count_bound", 128'(count_o), 128'd4);
            guard++;
        end
        chk("wrap_budget", 128'(guard < 200), 128'd1);
        chk("wrap_no_ovf", 128'(overflow_o), 128'd0);
        chk("wrap_out_len", 128'(outs.size()), 128'(ins.size()));
        for (int i = 0; i < ins.size() && i < outs.size(); i++) begin
            chk("wrap_seq", 128'(outs[i]), 128'(ins[i]));
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
